// File: rtl/imm_gen_pfx.sv
// rtl/imm_gen_pfx.sv - pipelined immediate generator with prefix extension
module imm_gen_pfx #(
  parameter int         INSTR_W    = 16,
  parameter int         XLEN       = 16,
  parameter int         PFX_W      = 8,
  parameter logic [3:0] PFX_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [2:0]         imm_src,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    imm_out,
  output logic               imm_extended,
  output logic               err
);

  // Scratch width large enough for {prefix, widest field} plus extension headroom.
  localparam int WW = PFX_W + 8 + XLEN;

  typedef enum logic {IDLE, PFX} state_e;

  state_e             state_q, state_d;
  logic [PFX_W-1:0]   pfx_q, pfx_d;
  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    imm_q, imm_d;
  logic               ext_q, ext_d;
  logic               err_q, err_d;

  logic               accept;
  logic               is_pfx;
  logic               bad_src;
  logic [7:0]         f_raw;
  int                 fw;
  int                 vw;
  logic               f_signed;
  logic               f_shift;
  logic [WW-1:0]      v;
  logic               sbit;
  logic [XLEN-1:0]    res;
  logic               unused_instr;

  assign unused_instr = ^instruction;

  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_pfx   = (instruction[INSTR_W-1 -: 4] == PFX_OPCODE);
  assign bad_src  = imm_src[2];

  // Field select and result formation for the current instruction.
  always_comb begin
    f_raw    = '0;
    fw       = 8;
    f_signed = 1'b1;
    f_shift  = 1'b0;
    case (imm_src[1:0])
      2'b00: begin
        f_raw = instruction[8:1];
      end
      2'b01: begin
        f_raw = {2'b00, instruction[5:0]};
        fw    = 6;
      end
      2'b10: begin
        f_raw    = {3'b000, instruction[5:1]};
        fw       = 5;
        f_signed = 1'b0;
      end
      default: begin
        f_raw   = instruction[8:1];
        f_shift = 1'b1;
      end
    endcase

    v  = {{(WW-8){1'b0}}, f_raw};
    vw = fw;
    if (state_q == PFX) begin
      v  = v | (WW'(pfx_q) << fw);
      vw = fw + PFX_W;
    end

    sbit = |(v & (WW'(1) << (vw - 1)));
    if (f_signed && sbit) begin
      v = v | ~((WW'(1) << vw) - WW'(1));
    end

    res = v[XLEN-1:0];
    if (f_shift) begin
      res = {res[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      state_d = is_pfx ? PFX : IDLE;
    end
  end

  always_comb begin
    pfx_d       = pfx_q;
    out_valid_d = out_valid_q;
    imm_d       = imm_q;
    ext_d       = ext_q;
    err_d       = 1'b0;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept && is_pfx) begin
      pfx_d = instruction[PFX_W-1:0];
      err_d = (state_q == PFX);
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      out_valid_d = 1'b1;
      if (bad_src) begin
        imm_d = '0;
        ext_d = 1'b0;
        err_d = 1'b1;
      end else begin
        imm_d = res;
        ext_d = (state_q == PFX);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pfx_q       <= '0;
      out_valid_q <= 1'b0;
      imm_q       <= '0;
      ext_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pfx_q       <= pfx_d;
      out_valid_q <= out_valid_d;
      imm_q       <= imm_d;
      ext_q       <= ext_d;
      err_q       <= err_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign imm_out      = imm_q;
  assign imm_extended = ext_q;
  assign err          = err_q;

endmodule
